// File: rtl/wb_sharedbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_sharedbus_arbiter
// Function : Wishbone B4 pipelined shared-bus interconnect, NM masters to NS
//            slaves, round-robin arbitration with address decode.
// Revision : 1.0
// ============================================================================
module wb_sharedbus_arbiter #(
   parameter int               NM        = 2,
   parameter int               NS        = 1,
   parameter logic [NS*32-1:0] BASE_ADDR = {32'h0000_0000},
   parameter logic [NS*32-1:0] SIZE      = {32'h0001_0000}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NM-1:0]            m_cyc,
   input  logic [NM-1:0]            m_stb,
   input  logic [NM-1:0]            m_we,
   input  logic [NM-1:0][31:0]      m_adr,
   input  logic [NM-1:0][3:0]       m_sel,
   input  logic [NM-1:0][31:0]      m_dat_w,
   output logic [NM-1:0][31:0]      m_dat_r,
   output logic [NM-1:0]            m_ack,
   output logic [NM-1:0]            m_err,
   output logic [NM-1:0]            m_stall,
   output logic [NS-1:0]            s_cyc,
   output logic [NS-1:0]            s_stb,
   output logic [NS-1:0]            s_we,
   output logic [NS-1:0][31:0]      s_adr,
   output logic [NS-1:0][3:0]       s_sel,
   output logic [NS-1:0][31:0]      s_dat_w,
   input  logic [NS-1:0][31:0]      s_dat_r,
   input  logic [NS-1:0]            s_ack,
   input  logic [NS-1:0]            s_err,
   input  logic [NS-1:0]            s_stall
);

   localparam int GW = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] gnt_q, gnt_d;
   logic [GW-1:0] last_q, last_d;
   logic          unmapped_q, unmapped_d;

   logic          granted;
   logic [31:0]   g_adr;
   logic [NS-1:0] hit_raw;
   logic [NS-1:0] hit_sel;
   logic          hit_any;
   logic          stall_hit;
   logic [31:0]   rdata;
   logic          rr_found;
   logic [GW-1:0] rr_pick;
   int            rr_idx;

   assign granted = (state_q == ST_GRANT);
   assign g_adr   = m_adr[gnt_q];

   // Region limit is formed in 33 bits so a region ending at 4 GiB still decodes.
   generate
      for (genvar s = 0; s < NS; s++) begin : g_dec
         logic [32:0] lim;
         assign lim        = {1'b0, BASE_ADDR[s*32 +: 32]} + {1'b0, SIZE[s*32 +: 32]};
         assign hit_raw[s] = (g_adr >= BASE_ADDR[s*32 +: 32]) && ({1'b0, g_adr} < lim);
      end
   endgenerate

   assign hit_sel   = hit_raw & (~hit_raw + NS'(1));
   assign hit_any   = |hit_raw;
   assign stall_hit = |(s_stall & hit_sel);

   // Round-robin search starts just after the last granted master.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_idx   = 0;
      for (int i = 1; i <= NM; i++) begin
         rr_idx = (int'(last_q) + i) % NM;
         if (!rr_found && m_cyc[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      unmapped_d = granted & m_cyc[gnt_q] & m_stb[gnt_q] & ~hit_any;
      if (!granted || !m_cyc[gnt_q]) begin
         if (rr_found) begin
            state_d = ST_GRANT;
            gnt_d   = rr_pick;
            last_d  = rr_pick;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         last_q     <= GW'(NM - 1);
         unmapped_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         unmapped_q <= unmapped_d;
      end
   end

   always_comb begin
      rdata = '0;
      for (int s = 0; s < NS; s++) begin
         s_cyc[s]   = granted & m_cyc[gnt_q] & hit_sel[s];
         s_stb[s]   = granted & m_cyc[gnt_q] & hit_sel[s] & m_stb[gnt_q];
         s_we[s]    = m_we[gnt_q];
         s_adr[s]   = g_adr;
         s_sel[s]   = m_sel[gnt_q];
         s_dat_w[s] = m_dat_w[gnt_q];
         rdata      = rdata | (s_dat_r[s] & {32{s_ack[s]}});
      end
   end

   always_comb begin
      m_stall = '1;
      m_ack   = '0;
      m_err   = '0;
      for (int m = 0; m < NM; m++) begin
         m_dat_r[m] = rdata;
      end
      if (granted) begin
         m_stall[gnt_q] = hit_any ? stall_hit : 1'b0;
         m_ack[gnt_q]   = |s_ack;
         m_err[gnt_q]   = (|s_err) | unmapped_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_sharedbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sharedbus_arbiter
// Function : Directed self-checking bench for wb_sharedbus_arbiter (2M x 1S).
// Revision : 1.0
// ============================================================================
module tb_wb_sharedbus_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        m_cyc, m_stb, m_we;
   logic [1:0][31:0]  m_adr, m_dat_w, m_dat_r;
   logic [1:0][3:0]   m_sel;
   logic [1:0]        m_ack, m_err, m_stall;
   logic [0:0]        s_cyc, s_stb, s_we;
   logic [0:0][31:0]  s_adr, s_dat_w, s_dat_r;
   logic [0:0][3:0]   s_sel;
   logic [0:0]        s_ack, s_err, s_stall;

   int checks = 0;
   int errors = 0;

   wb_sharedbus_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
      .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
      .m_stall(m_stall),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
      .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
      .s_stall(s_stall)
   );

   always #5 clk = ~clk;

   // Inputs change just after the rising edge; outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_dat_w = '0;
      s_dat_r = '0; s_ack = '0; s_err = '0; s_stall = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b expected 11", m_stall); end
      checks++;
      if ({m_ack, m_err} !== 4'b0000) begin errors++; $display("FAIL reset_ackerr: got %b expected 0000", {m_ack, m_err}); end
      checks++;
      if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL reset_scyc: got %b expected 00", {s_cyc, s_stb}); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0100; m_sel[0] = 4'hF;
      @(negedge clk);
      checks++;
      if (m_stall[0] !== 1'b1 || s_stb !== 1'b0) begin errors++; $display("FAIL read_arb_stall: got stall=%b stb=%b expected 1/0", m_stall[0], s_stb); end
      tick();
      @(negedge clk);
      checks++;
      if (m_stall[0] !== 1'b0 || s_stb !== 1'b1 || s_adr[0] !== 32'h100) begin
         errors++; $display("FAIL read_stb: got stall=%b stb=%b adr=%h expected 0/1/00000100", m_stall[0], s_stb, s_adr[0]);
      end
      tick();
      m_stb[0] = 1'b0; s_ack = 1'b1; s_dat_r[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (m_ack !== 2'b01 || m_dat_r[0] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL read_ack: got ack=%b dat=%h expected 01/deadbeef", m_ack, m_dat_r[0]);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_contention();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_cyc = 2'b11;
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b11) begin errors++; $display("FAIL cont_idle: got %b expected 11", m_stall); end
      tick();
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b10 || s_cyc !== 1'b1) begin errors++; $display("FAIL cont_first_m0: got stall=%b cyc=%b expected 10/1", m_stall, s_cyc); end
      tick();
      m_cyc = 2'b10;
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b10 || s_cyc !== 1'b0) begin errors++; $display("FAIL cont_release: got stall=%b cyc=%b expected 10/0", m_stall, s_cyc); end
      tick();
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b01 || s_cyc !== 1'b1) begin errors++; $display("FAIL cont_handover_m1: got stall=%b cyc=%b expected 01/1", m_stall, s_cyc); end
      tick();
      m_cyc = 2'b00;
      tick();
      m_cyc = 2'b11;
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b11) begin errors++; $display("FAIL cont_idle2: got %b expected 11", m_stall); end
      tick();
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b10) begin errors++; $display("FAIL cont_rr_m0: got %b expected 10", m_stall); end
      tick();
      m_cyc = 2'b00;
      tick();
   endtask

   task automatic test_unmapped();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h0001_0000;
      m_sel[1] = 4'h3; m_dat_w[1] = 32'hCAFE_F00D;
      tick();
      @(negedge clk);
      checks++;
      if (m_stall[1] !== 1'b0 || s_stb !== 1'b0 || s_cyc !== 1'b0 || m_err !== 2'b00) begin
         errors++; $display("FAIL unmap_accept: got stall=%b stb=%b cyc=%b err=%b expected 0/0/0/00", m_stall[1], s_stb, s_cyc, m_err);
      end
      tick();
      m_stb[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (m_err !== 2'b10) begin errors++; $display("FAIL unmap_err: got %b expected 10", m_err); end
      tick();
      @(negedge clk);
      checks++;
      if (m_err !== 2'b00) begin errors++; $display("FAIL unmap_err_pulse: got %b expected 00", m_err); end
      tick();
      m_stb[1] = 1'b1; m_adr[1] = 32'h0000_FFFC;
      @(negedge clk);
      checks++;
      if (s_stb !== 1'b1 || s_we !== 1'b1 || s_sel[0] !== 4'h3 || s_dat_w[0] !== 32'hCAFE_F00D || m_stall[1] !== 1'b0) begin
         errors++; $display("FAIL boundary_hit: got stb=%b we=%b sel=%h dat=%h stall=%b expected 1/1/3/cafef00d/0", s_stb, s_we, s_sel[0], s_dat_w[0], m_stall[1]);
      end
      tick();
      m_stb[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (m_err !== 2'b00) begin errors++; $display("FAIL boundary_noerr: got %b expected 00", m_err); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_stall();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0200; s_stall = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (m_stall[0] !== 1'b1 || s_stb !== 1'b1 || s_adr[0] !== 32'h200) begin
            errors++; $display("FAIL stall_hold[%0d]: got stall=%b stb=%b adr=%h expected 1/1/00000200", i, m_stall[0], s_stb, s_adr[0]);
         end
         tick();
      end
      s_stall = 1'b0;
      @(negedge clk);
      checks++;
      if (m_stall[0] !== 1'b0 || s_stb !== 1'b1) begin errors++; $display("FAIL stall_release: got stall=%b stb=%b expected 0/1", m_stall[0], s_stb); end
      tick();
      m_stb[0] = 1'b0; s_ack = 1'b1; s_dat_r[0] = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (m_ack !== 2'b01 || m_dat_r[0] !== 32'h1234_5678) begin errors++; $display("FAIL stall_ack: got ack=%b dat=%h expected 01/12345678", m_ack, m_dat_r[0]); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      m_cyc[0] = 1'b1;
      tick();
      m_stb[0] = 1'b1; m_adr[0] = 32'h0;
      tick();
      m_adr[0] = 32'h4;
      tick();
      m_stb[0] = 1'b0; rst_n = 1'b0; s_ack = 1'b1; s_dat_r[0] = 32'h0BAD_0BAD;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (m_ack !== 2'b00 || m_err !== 2'b00 || m_stall !== 2'b11 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs: got ack=%b err=%b stall=%b cyc=%b stb=%b expected 00/00/11/0/0", m_ack, m_err, m_stall, s_cyc, s_stb);
      end
      tick();
      s_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (m_stall !== 2'b10 || s_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: got stall=%b cyc=%b expected 10/1", m_stall, s_cyc); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_dat;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0;
      tick();
      for (int i = 0; i < 5; i++) begin
         m_stb[1] = (i < 4);
         m_adr[1] = 32'(4 * i);
         s_ack    = (i >= 1);
         exp_dat  = 32'hA5A5_0000 ^ 32'(4 * (i - 1));
         s_dat_r[0] = (i >= 1) ? exp_dat : 32'h0;
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if (s_stb !== 1'b1 || s_adr[0] !== 32'(4 * i) || m_stall[1] !== 1'b0) begin
               errors++; $display("FAIL b2b_stb[%0d]: got stb=%b adr=%h stall=%b expected 1/%h/0", i, s_stb, s_adr[0], m_stall[1], 32'(4 * i));
            end
         end
         if (i >= 1) begin
            checks++;
            if (m_ack !== 2'b10 || m_dat_r[1] !== exp_dat) begin
               errors++; $display("FAIL b2b_ack[%0d]: got ack=%b dat=%h expected 10/%h", i, m_ack, m_dat_r[1], exp_dat);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_unmapped();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
